// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack bus access per instruction, load extraction, LL bit, alignment flag.
// Accesses take issue + ack + one DONE cycle; stall_req holds the pipeline until the ack (even after a flush).
module mem_access_unit #(
   parameter bit KSEG_STRIP = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        flush,
   input  logic        m_en,
   input  logic [3:0]  m_wen,
   input  logic [31:0] m_vaddr,
   input  logic [31:0] m_wdata,
   input  logic [1:0]  ld_size,
   input  logic        ld_sign,
   input  logic [31:0] alures,
   input  logic [3:0]  wreg,
   input  logic [4:0]  wraddr,
   input  logic        llb_wen,
   input  logic        llbit,
   input  logic        llb_clr,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        stall_req,
   output logic [31:0] wb_wdata,
   output logic [3:0]  wb_wreg,
   output logic [4:0]  wb_wraddr,
   output logic        align_err,
   output logic        llbit_q
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nx;
   logic [31:0] rdata_q;
   logic        aborted, aborted_nx;
   logic        req, stall;
   logic        is_load, misalign, align_raw, issue, commit, load_pend;
   logic [1:0]  acc_size;
   logic [3:0]  load_be;
   logic [31:0] paddr, load_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign is_load = (m_wen == 4'h0);

   // Store width comes from how many byte lanes are enabled.
   always_comb begin
      acc_size = ld_size;
      if (!is_load) begin
         case ($countones(m_wen))
            2:       acc_size = 2'd1;
            4:       acc_size = 2'd2;
            default: acc_size = 2'd0;
         endcase
      end
   end

   assign misalign  = ((acc_size == 2'd1) & m_vaddr[0]) |
                      ((acc_size == 2'd2) & (m_vaddr[1:0] != 2'b00));
   assign align_raw = m_en & misalign;
   assign issue     = m_en & !align_raw & !flush;
   assign paddr     = (KSEG_STRIP && (m_vaddr[31:30] == 2'b10)) ? {3'b000, m_vaddr[28:0]} : m_vaddr;

   always_comb begin
      load_be = 4'hF;
      case (ld_size)
         2'd0:    load_be = 4'b0001 << m_vaddr[1:0];
         2'd1:    load_be = m_vaddr[1] ? 4'b1100 : 4'b0011;
         default: load_be = 4'hF;
      endcase
   end

   always_comb begin
      state_nx   = state;
      aborted_nx = aborted;
      req        = 1'b0;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (issue) begin
               req      = 1'b1;
               stall    = 1'b1;
               state_nx = REQ;
            end
         end
         REQ: begin
            // The bus cycle cannot be withdrawn; a flush only marks the result as dead.
            req   = 1'b1;
            stall = 1'b1;
            if (bus_ack) begin
               state_nx   = (aborted | flush) ? IDLE : DONE;
               aborted_nx = 1'b0;
            end else if (flush) begin
               aborted_nx = 1'b1;
            end
         end
         DONE: begin
            if (flush | !stall_in)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign commit = !stall_in & !stall & !flush & !align_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rdata_q <= 32'h0;
         aborted <= 1'b0;
         llbit_q <= 1'b0;
      end else begin
         state   <= state_nx;
         aborted <= aborted_nx;
         if ((state == REQ) && bus_ack)
            rdata_q <= bus_rdata;
         if (commit) begin
            if (llb_clr)
               llbit_q <= 1'b0;
            else if (llb_wen)
               llbit_q <= llbit;
         end
      end
   end

   always_comb begin
      case (m_vaddr[1:0])
         2'd0:    byte_sel = rdata_q[7:0];
         2'd1:    byte_sel = rdata_q[15:8];
         2'd2:    byte_sel = rdata_q[23:16];
         default: byte_sel = rdata_q[31:24];
      endcase
      half_sel = m_vaddr[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (ld_size)
         2'd0:    load_data = {{24{ld_sign & byte_sel[7]}}, byte_sel};
         2'd1:    load_data = {{16{ld_sign & half_sel[15]}}, half_sel};
         default: load_data = rdata_q;
      endcase
   end

   assign load_pend = m_en & is_load & (state != DONE);

   // Reset also forces the combinational outputs low while it is held.
   assign bus_req   = req & !rst;
   assign bus_wr    = bus_req & !is_load;
   assign bus_be    = bus_req ? (is_load ? load_be : m_wen) : 4'h0;
   assign bus_addr  = bus_req ? paddr : 32'h0;
   assign bus_wdata = bus_req ? m_wdata : 32'h0;
   assign stall_req = stall & !rst;
   assign align_err = align_raw & !rst;
   assign wb_wdata  = rst ? 32'h0 : ((m_en & is_load) ? load_data : alures);
   assign wb_wreg   = (rst | flush | align_raw | load_pend) ? 4'h0 : wreg;
   assign wb_wraddr = rst ? 5'h0 : wraddr;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access block, directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Consumes the registered EX results and issues at most one load/store per instruction on a req/ack data bus.
- Asserts a stall request while an access is outstanding, then extracts and extends load data.
- Owns the LL bit register and raises an alignment-error flag.

Parameters:
- KSEG_STRIP, 1, 1 = for vaddr[31:30]==2'b10 (kseg0/kseg1), translate paddr = {3'b000, vaddr[28:0]}; 0 = paddr equals vaddr.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_in  in  1  stall on this stage from downstream/other units; instruction does not leave MEM.
- flush  in  1  kill the instruction in MEM.
- m_en  in  1  memory access valid.
- m_wen  in  4  store byte enables, already lane-aligned; 0 = load.
- m_vaddr  in  32  virtual address.
- m_wdata  in  32  store data, already lane-aligned.
- ld_size  in  2  0 byte, 1 half, 2 word.
- ld_sign  in  1  sign-extend sub-word load.
- alures  in  32  non-memory result.
- wreg  in  4  register byte write enables.
- wraddr  in  5  destination register.
- llb_wen  in  1  write LL bit at commit.
- llbit  in  1  value written to the LL bit.
- llb_clr  in  1  clear LL bit (exception return).
- bus_req  out  1  data bus request.
- bus_wr  out  1  1 = write.
- bus_be  out  4  byte enables.
- bus_addr  out  32  physical address.
- bus_wdata  out  32  write data.
- bus_ack  in  1  access complete; rdata valid this cycle.
- bus_rdata  in  32  read data.
- stall_req  out  1  hold pipeline at and above MEM.
- wb_wdata  out  32  result to MEM/WB.
- wb_wreg  out  4  write enables to MEM/WB.
- wb_wraddr  out  5  destination to MEM/WB.
- align_err  out  1  misaligned access (combinational).
- llbit_q  out  1  current LL bit.

Behaviour:
- Reset: FSM=IDLE, rdata_q=0, aborted=0, llbit_q=0. All bus outputs 0; stall_req=0; wb_* = 0.
- align_err = m_en & ((ld_size==1 & vaddr[0]) | (ld_size==2 & vaddr[1:0]!=0)); store size is decoded the same way from m_wen popcount (1/2/4).
- An access is issued only when m_en & !align_err & !flush.
- FSM states:
  - IDLE → REQ when an access is issued. bus_req rises in the same cycle, combinationally from the inputs; stall_req=1.
  - REQ: bus_req/bus_wr/bus_be/bus_addr/bus_wdata held from inputs (stable, since the pipeline is stalled); stall_req=1.
    - On bus_ack: capture bus_rdata into rdata_q and go to DONE (or to IDLE if aborted).
    - Minimum latency is 2 cycles (issue, ack) plus 1 DONE cycle.
  - DONE: bus_req=0, stall_req=0, result taken from rdata_q. Stay in DONE while stall_in=1; go to IDLE when stall_in=0 (the pipeline advances that edge) or on flush.
- Flush in REQ: the bus transaction cannot be cancelled. Set aborted=1 and keep stall_req=1 until ack, then go to IDLE with the result discarded; aborted clears.
- Flush in IDLE/DONE: no bus activity; wb_wreg=0.
- wb_wraddr = wraddr; wb_wreg = wreg, but forced to 0 on flush, on align_err, and in IDLE/REQ when a load is pending.
- Load extraction from the selected word (DONE: rdata_q). Little-endian lane = vaddr[1:0] (byte) / vaddr[1] (half); extend by ld_sign. Word loads pass through.
- Non-memory instruction: wb_wdata = alures in IDLE, zero latency, no stall.
- Stores: wb_wdata = alures.
- LL bit:
  - Commit = !stall_in & !stall_req & !flush & !align_err.
  - On commit with llb_wen: llbit_q <= llbit.
  - llb_clr has priority over the write (same cycle → 0).
- rst mid-REQ: FSM goes to IDLE immediately, bus_req drops; a late bus_ack in IDLE is ignored.

Test Plan:
- Word load at vaddr 0x8000_0010 with ack on the 3rd cycle → bus_addr=0x0000_0010, bus_be=4'hF, stall_req high 3 cycles, DONE wb_wdata=bus_rdata.
- Byte load at vaddr 0xA000_0003, ld_sign=1, rdata=0x80FF_1234 → wb_wdata=0xFFFF_FF80; with ld_sign=0 → 0x0000_0080.
- Half load at vaddr 0x...01 → align_err=1, bus_req never asserts, wb_wreg=0, llbit unchanged.
- Store m_wen=4'b0011, wdata=0x0000_BEEF, ack in 1 cycle → bus_wr=1, bus_be=4'h3; stall_in held 2 cycles → remains in DONE with no second bus_req.
- Flush during REQ, ack 2 cycles later → stall_req stays high until ack, then IDLE with wb_wreg=0; the next load issues normally.
- LL commit with llbit=1, then llb_clr and llb_wen with llbit=1 in the same cycle → llbit_q=1 then 0; assert rst mid-REQ → all outputs 0 asynchronously.
